// File: rtl/mac_psum_drain.sv
// Drains packed psum vectors from the MAC array into the output SRAM,
// splitting each vector into SRAM_DW-wide beats written at consecutive addresses.
module mac_psum_drain #(
  parameter int PS_W      = 32,
  parameter int LANES_OUT = 256,
  parameter int SRAM_DW   = 512,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_en,
  input  logic [LANES_OUT*PS_W-1:0] psum_vec,
  input  logic                      psum_vld,
  output logic                      psum_rdy,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [CNT_W-1:0]          num_vecs,
  input  logic                      abort,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [SRAM_DW-1:0]        mem_wdata,
  input  logic                      mem_gnt,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          vecs_written
);

  localparam int VEC_W  = LANES_OUT * PS_W;
  localparam int BEATS  = VEC_W / SRAM_DW;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VEC,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Vector held as an array of beats so beat 0 is the lowest SRAM_DW bits.
  logic [BEATS-1:0][SRAM_DW-1:0] vec_reg;
  logic [BEAT_W-1:0]             beat;
  logic [ADDR_W-1:0]             addr_ptr;
  logic [CNT_W-1:0]              num_reg;

  logic cmd_go;
  logic accept;
  logic beat_gnt;
  logic last_beat;
  logic last_vec;

  assign cmd_go    = clk_en && (state == IDLE) && start && !abort;
  assign accept    = psum_vld && psum_rdy;
  assign beat_gnt  = clk_en && (state == WRITE) && mem_gnt;
  assign last_beat = (beat == LAST_BEAT);
  assign last_vec  = ((vecs_written + CNT_W'(1)) == num_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = (num_vecs != '0) ? WAIT_VEC : DONE;
          end
        end
        WAIT_VEC: begin
          if (psum_vld) begin
            state_nxt = WRITE;
          end
        end
        WRITE: begin
          if (mem_gnt && last_beat) begin
            state_nxt = last_vec ? DONE : WAIT_VEC;
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // A write granted in the same cycle as abort still advances the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_reg      <= '0;
      beat         <= '0;
      addr_ptr     <= '0;
      num_reg      <= '0;
      vecs_written <= '0;
    end else begin
      if (cmd_go) begin
        addr_ptr     <= base_addr;
        num_reg      <= num_vecs;
        vecs_written <= '0;
        beat         <= '0;
      end
      if (accept) begin
        vec_reg <= psum_vec;
        beat    <= '0;
      end
      if (beat_gnt) begin
        addr_ptr <= addr_ptr + ADDR_W'(1);
        if (last_beat) begin
          vecs_written <= vecs_written + CNT_W'(1);
        end else begin
          beat <= beat + BEAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    psum_rdy  = clk_en && (state == WAIT_VEC) && !abort;
    mem_we    = clk_en && (state == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WRITE) begin
      mem_addr  = addr_ptr;
      mem_wdata = vec_reg[beat];
    end
    busy = (state != IDLE);
    done = clk_en && (state == DONE);
  end

endmodule
